// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : 16x oversampling UART receiver. Frame = start(0), 8 data bits
//            LSB first, even parity, stop(1). Delivers the byte with a
//            one-cycle valid strobe and level parity / framing error flags.
// Options  : `UART_RX_MAJORITY_EN -- when defined, each bit is the 2-of-3
//            majority of the samples around the bit midpoint; otherwise a
//            single midpoint sample is used.
// Revision : 1.0  initial release
// ============================================================================
module uart_receiver #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       Rx_D,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    // Clocks per sample tick, rounded to nearest.
    function automatic logic [14:0] f_div(input int unsigned baud);
        int unsigned v;
        v = (CLK_HZ + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
        return v[14:0];
    endfunction

    localparam logic [14:0] c_DIV_300    = f_div(300);
    localparam logic [14:0] c_DIV_1200   = f_div(1200);
    localparam logic [14:0] c_DIV_4800   = f_div(4800);
    localparam logic [14:0] c_DIV_9600   = f_div(9600);
    localparam logic [14:0] c_DIV_19200  = f_div(19200);
    localparam logic [14:0] c_DIV_38400  = f_div(38400);
    localparam logic [14:0] c_DIV_57600  = f_div(57600);
    localparam logic [14:0] c_DIV_115200 = f_div(115200);

    // Sample tick inside a bit that sits at the bit midpoint.
    localparam logic [3:0]  c_MID = 4'(OVERSAMPLE / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [14:0] r_div;
    logic [14:0] r_div_max;
    logic [7:0]  r_tcnt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_perr;
    logic        r_s8;

    logic [14:0] w_div_sel;
    logic        w_fall;
    logic        w_tick;
    logic [7:0]  w_tnext;
    logic        w_mid;
    logic        w_eval;
    logic        w_bit;
    logic        w_stop;

    // Baud table: terminal count of the divider for the selected rate.
    always_comb begin
        w_div_sel = c_DIV_115200 - 15'd1;
        case (baud_select)
            3'd0:    w_div_sel = c_DIV_300    - 15'd1;
            3'd1:    w_div_sel = c_DIV_1200   - 15'd1;
            3'd2:    w_div_sel = c_DIV_4800   - 15'd1;
            3'd3:    w_div_sel = c_DIV_9600   - 15'd1;
            3'd4:    w_div_sel = c_DIV_19200  - 15'd1;
            3'd5:    w_div_sel = c_DIV_38400  - 15'd1;
            3'd6:    w_div_sel = c_DIV_57600  - 15'd1;
            default: w_div_sel = c_DIV_115200 - 15'd1;
        endcase
    end

    assign w_fall  = r_prev & ~r_sync2;
    assign w_tick  = (r_div == r_div_max) && (r_state != S_IDLE);
    assign w_tnext = r_tcnt + 8'd1;
    assign w_mid   = w_tick && (w_tnext[3:0] == c_MID);

`ifdef UART_RX_MAJORITY_EN
    logic r_s7;

    // Start/data/parity resolve one tick after the midpoint with a 2-of-3
    // vote. The stop bit must resolve on the fixed output cycle, so its third
    // vote is the line value on the clock following the midpoint tick.
    assign w_eval = w_tick && (w_tnext[3:0] == c_MID + 4'd1);
    assign w_bit  = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
    assign w_stop = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);

    // Capture the sample one tick before the midpoint for the vote.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s7 <= 1'b1;
        end else if (w_tick && (w_tnext[3:0] == c_MID - 4'd1)) begin
            r_s7 <= r_sync2;
        end
    end
`else
    assign w_eval = w_mid;
    assign w_bit  = r_sync2;
    assign w_stop = r_s8;
`endif

    // Synchronizer, baud divider, frame FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_prev    <= 1'b1;
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_div_max <= '0;
            r_tcnt    <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_s8      <= 1'b1;
            Rx_DATA   <= 8'h00;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            r_sync1  <= Rx_D;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            Rx_VALID <= 1'b0;

            if (!Rx_EN) begin
                // Silent abort: outputs keep their last values.
                r_state <= S_IDLE;
            end else begin
                if (r_state != S_IDLE) begin
                    if (w_tick) begin
                        r_div  <= '0;
                        r_tcnt <= w_tnext;
                    end else begin
                        r_div  <= r_div + 15'd1;
                    end
                    if (w_mid) begin
                        r_s8 <= r_sync2;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_fall) begin
                            r_div     <= '0;
                            r_tcnt    <= '0;
                            r_bitcnt  <= '0;
                            r_div_max <= w_div_sel;
                            Rx_PERROR <= 1'b0;
                            Rx_FERROR <= 1'b0;
                            r_state   <= S_START;
                        end
                    end
                    S_START: begin
                        if (w_eval) begin
                            r_state <= w_bit ? S_IDLE : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_eval) begin
                            r_shift  <= {w_bit, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_state <= S_PARITY;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_eval) begin
                            r_perr  <= (^r_shift) ^ w_bit;
                            r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_mid) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        Rx_DATA   <= r_shift;
                        Rx_PERROR <= r_perr;
                        Rx_FERROR <= ~w_stop;
                        Rx_VALID  <= ~r_perr & w_stop;
                        r_state   <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Receive side of the UARTSystem serial link. Accepts the same frame the transmitter produces:
- 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Uses the same 3-bit baud_select table and 100 MHz clock.

Oversamples the line at 16× baud, recovers each byte, checks parity and framing, and presents the byte with a one-cycle valid strobe to the consumer logic.

## Interface

Parameters:
- CLK_HZ, 100000000, system clock frequency used to derive divider constants.
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16, other values unsupported.

Ports (one clock; reset is synchronous and active-high; clock port `clk`, reset port `reset`):
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- baud_select  input  3  baud rate: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
- Rx_EN  input  1  receiver enable; 0 holds receiver idle.
- Rx_D  input  1  serial line, asynchronous, idles high.
- Rx_DATA  output  8  last received byte.
- Rx_VALID  output  1  one-cycle pulse: good frame in Rx_DATA.
- Rx_PERROR  output  1  parity error on last frame (level).
- Rx_FERROR  output  1  framing error (stop bit = 0) on last frame (level).

## Operation

- Rx_D passes through a 2-flop synchronizer; all logic uses the synchronized value.
- Baud divider values (clocks per sample tick, 100 MHz) for baud_select 0–7: 20833, 5208, 1302, 651, 326, 163, 109, 54.
- The divider restarts at start-edge detection.
- baud_select is latched at start detection and held for the whole frame; changes mid-frame are ignored.
- FSM states:
  - IDLE: wait for synchronized Rx_D 1→0 while Rx_EN=1. On detection, clear Rx_PERROR and Rx_FERROR, reset tick and bit counters, go to START.
  - START: at tick 8, sample the line. If 1 (glitch), return to IDLE with no output. If 0, go to DATA.
  - DATA: sample every 16 ticks, at bit midpoint, into a shift register, LSB first. After 8 bits, go to PARITY.
  - PARITY: sample the parity bit. Error if the XOR of the 8 data bits XOR the parity bit is 1. Go to STOP.
  - STOP: sample the stop bit. On the following clock, load Rx_DATA and set Rx_PERROR and Rx_FERROR (FERROR if the stop sample is 0). Pulse Rx_VALID only if both errors are 0. Return to IDLE.
- Rx_DATA is loaded on every completed frame, including errored frames. Glitch-rejected and aborted frames do not load it.
- Rx_EN=0 at any time forces IDLE; any frame in progress is aborted silently. Rx_DATA and error flags are unchanged.
- Line held low through the stop bit (break): data 0x00 with Rx_FERROR=1, no Rx_VALID.
- After STOP, a new start edge is accepted immediately. This supports back-to-back frames with no idle gap beyond the stop bit's second half.

## Timing

- Reset values:
  - Rx_DATA = 8'h00; Rx_VALID, Rx_PERROR, Rx_FERROR = 0.
  - FSM in IDLE; divider, counters and shift register cleared.
  - Both synchronizer flops = 1.
- Reset asserted mid-frame takes effect on the next clock edge and aborts the frame.
- Start detection happens 3 clocks after the line falls: 2 synchronizer stages plus 1 edge register.
- Sample points, counted from detection: tick 8 (start), then 8+16k for k=1..8 (data), 152 (parity), 168 (stop).
- Rx_VALID rises on the clock after the tick-168 sample, i.e. 168·N + 1 clocks after detection, where N is the divider value. It is high for exactly 1 clock.
- Rx_PERROR and Rx_FERROR change in the same cycle as Rx_VALID would. They hold until the next start detection or reset.

## Configuration

- `UART_RX_MAJORITY_EN`:
  - Defined: each bit value is the 2-of-3 majority of the samples at ticks 7, 8 and 9 of that bit. Start-glitch rejection uses the same vote.
  - Undefined: single sample at tick 8.
- Latency to Rx_VALID is identical in both builds: the vote resolves by tick 9, and the output still updates at the tick-168-referenced cycle plus 1.

## Test plan

- Good frame: baud_select=7, send 0xA5 with parity 0 and stop 1 → Rx_DATA=8'hA5, one-cycle Rx_VALID at 168·54+1 clocks ±1 after detection, both errors 0.
- Parity error: 0xA5 with parity 1 → Rx_DATA=8'hA5, Rx_PERROR=1, Rx_VALID never asserted, Rx_FERROR=0. A following good 0x3C frame clears PERROR and pulses VALID.
- Framing error: 0x0F, parity 0, stop 0 → Rx_FERROR=1, no Rx_VALID.
- Start glitch: baud_select=3, Rx_D low for 3·651 clocks, then high → no state change, no outputs, the next real frame is received correctly.
- Reset / enable abort: assert reset (or drop Rx_EN) after data bit 3 of 0xFF → no Rx_VALID. Under reset all outputs go to reset values next cycle. The following 0x81 frame (parity 0) is received cleanly.
- Back-to-back: baud_select=7, frames 0x55 and 0xAA with no idle gap → two Rx_VALID pulses 11·16·54 clocks apart, with the correct data for each.
